// File: rtl/zap_shift_pkg.sv
// rtl/zap_shift_pkg.sv - shift-type encodings and the normalised entry carried to the barrel shifter
package zap_shift_pkg;

  typedef enum logic [2:0] {
    SH_LSL     = 3'd0,
    SH_LSR     = 3'd1,
    SH_ASR     = 3'd2,
    SH_ROR     = 3'd3,
    SH_RORI    = 3'd4,
    SH_ROR_1   = 3'd5,
    SH_RRC     = 3'd6,
    SH_LSL_SAT = 3'd7
  } shift_type_t;

  localparam logic [1:0] ARM_LSL = 2'd0;
  localparam logic [1:0] ARM_LSR = 2'd1;
  localparam logic [1:0] ARM_ASR = 2'd2;
  localparam logic [1:0] ARM_ROR = 2'd3;

  localparam int SHIFT_TAG_W = 8;

  typedef struct packed {
    logic [31:0]            source;
    logic [7:0]             amount;
    shift_type_t            shift_type;
    logic                   carry;
    logic [SHIFT_TAG_W-1:0] tag;
  } shift_entry_t;

endpackage

// File: rtl/zap_shift_operand_norm.sv
// rtl/zap_shift_operand_norm.sv - maps raw ARM shift fields onto the extended shifter encoding
// Optional ZAP_SHIFT_SAT_EN: i_sat_dbl forces an LSL_SAT #1 doubling entry.
module zap_shift_operand_norm
  import zap_shift_pkg::*;
(
  input  logic [31:0]            i_source,
  input  logic [31:0]            i_rs,
  input  logic                   i_reg_shift,
  input  logic [4:0]             i_imm_amt,
  input  logic [1:0]             i_shtype,
  input  logic                   i_carry,
  input  logic                   i_sat_dbl,
  input  logic [SHIFT_TAG_W-1:0] i_tag,
  output shift_entry_t           o_entry
);

  // Register-specified shifts use only the low byte of Rs.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_rs[31:8]};

`ifndef ZAP_SHIFT_SAT_EN
  logic unused_sat;
  assign unused_sat = i_sat_dbl;
`endif

  always_comb begin
    o_entry        = '0;
    o_entry.source = i_source;
    o_entry.carry  = i_carry;
    o_entry.tag    = i_tag;
    if (i_reg_shift) begin
      o_entry.shift_type = shift_type_t'({1'b0, i_shtype});
      o_entry.amount     = i_rs[7:0];
    end else begin
      o_entry.amount = {3'b000, i_imm_amt};
      unique case (i_shtype)
        ARM_LSL: o_entry.shift_type = SH_LSL;
        ARM_LSR: begin
          o_entry.shift_type = SH_LSR;
          if (i_imm_amt == 5'd0) o_entry.amount = 8'd32;
        end
        ARM_ASR: begin
          o_entry.shift_type = SH_ASR;
          if (i_imm_amt == 5'd0) o_entry.amount = 8'd32;
        end
        default: begin
          // ROR #0 is the RRX encoding; non-zero immediates rotate without the register-ROR carry rules.
          o_entry.shift_type = (i_imm_amt == 5'd0) ? SH_RRC : SH_RORI;
        end
      endcase
    end
`ifdef ZAP_SHIFT_SAT_EN
    if (i_sat_dbl) begin
      o_entry.shift_type = SH_LSL_SAT;
      o_entry.amount     = 8'd1;
    end
`endif
  end

endmodule

// File: rtl/zap_shift_operand_stage.sv
// rtl/zap_shift_operand_stage.sv - registered shift-operand stage with one-entry skid buffer
// Optional ZAP_SHIFT_SAT_EN enables saturating-double entries in the normaliser.
module zap_shift_operand_stage
  import zap_shift_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_source,
  input  logic [31:0]      i_rs,
  input  logic             i_reg_shift,
  input  logic [4:0]       i_imm_amt,
  input  logic [1:0]       i_shtype,
  input  logic             i_carry,
  input  logic             i_sat_dbl,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_source,
  output logic [7:0]       o_amount,
  output logic [2:0]       o_shift_type,
  output logic             o_carry,
  output logic [TAG_W-1:0] o_tag
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state;
  shift_entry_t norm;
  shift_entry_t out_q;
  shift_entry_t skid_q;
  logic         accept;
  logic         drain;

  zap_shift_operand_norm u_norm (
    .i_source    (i_source),
    .i_rs        (i_rs),
    .i_reg_shift (i_reg_shift),
    .i_imm_amt   (i_imm_amt),
    .i_shtype    (i_shtype),
    .i_carry     (i_carry),
    .i_sat_dbl   (i_sat_dbl),
    .i_tag       (SHIFT_TAG_W'(i_tag)),
    .o_entry     (norm)
  );

  assign accept = i_valid & o_ready;
  assign drain  = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= EMPTY;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (i_flush) begin
      state   <= EMPTY;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_q   <= norm;
            o_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_q <= norm;
          end else if (accept) begin
            skid_q  <= norm;
            o_ready <= 1'b0;
            state   <= TWO;
          end else if (drain) begin
            o_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        default: begin
          // o_ready is low here, so only a drain can move the skid entry forward.
          if (drain) begin
            out_q   <= skid_q;
            o_ready <= 1'b1;
            state   <= ONE;
          end
        end
      endcase
    end
  end

  assign o_source     = out_q.source;
  assign o_amount     = out_q.amount;
  assign o_shift_type = out_q.shift_type;
  assign o_carry      = out_q.carry;
  assign o_tag        = TAG_W'(out_q.tag);

endmodule

// File: tb/tb_zap_shift_operand_stage.sv
// tb/tb_zap_shift_operand_stage.sv - self-checking bench for zap_shift_operand_stage
module tb_zap_shift_operand_stage;

  typedef struct packed {
    logic [31:0] src;
    logic [7:0]  amt;
    logic [2:0]  ty;
    logic        c;
    logic [7:0]  tag;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_source = '0;
  logic [31:0] i_rs = '0;
  logic        i_reg_shift = 1'b0;
  logic [4:0]  i_imm_amt = '0;
  logic [1:0]  i_shtype = '0;
  logic        i_carry = 1'b0;
  logic        i_sat_dbl = 1'b0;
  logic [7:0]  i_tag = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_source;
  logic [7:0]  o_amount;
  logic [2:0]  o_shift_type;
  logic        o_carry;
  logic [7:0]  o_tag;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t exp_e;

  zap_shift_operand_stage #(.TAG_W(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_source(i_source), .i_rs(i_rs),
    .i_reg_shift(i_reg_shift), .i_imm_amt(i_imm_amt), .i_shtype(i_shtype),
    .i_carry(i_carry), .i_sat_dbl(i_sat_dbl), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_source(o_source),
    .o_amount(o_amount), .o_shift_type(o_shift_type), .o_carry(o_carry),
    .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  // Reference: ARM shift semantics written directly as a rule table.
  function automatic exp_t model(input logic [31:0] src, input logic [31:0] rs,
                                 input logic reg_sh, input logic [4:0] imm,
                                 input logic [1:0] ty, input logic c,
                                 input logic sat, input logic [7:0] tag);
    exp_t e;
    e.src = src; e.c = c; e.tag = tag;
    if (reg_sh) begin
      e.ty  = 3'(ty);
      e.amt = 8'(rs % 256);
    end else if (ty == 2'd0) begin
      e.ty = 3'd0; e.amt = 8'(imm);
    end else if (ty == 2'd3) begin
      e.ty  = (imm == 0) ? 3'd6 : 3'd4;
      e.amt = 8'(imm);
    end else begin
      e.ty  = 3'(ty);
      e.amt = (imm == 0) ? 8'd32 : 8'(imm);
    end
`ifdef ZAP_SHIFT_SAT_EN
    if (sat) begin e.ty = 3'd7; e.amt = 8'd1; end
`else
    if (sat) e.ty = e.ty;
`endif
    return e;
  endfunction

  task automatic tick();
    logic acc, drn;
    acc = i_valid & o_ready;
    drn = o_valid & i_ready;
    @(posedge i_clk);
    if (i_flush) q.delete();
    else begin
      if (drn && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(model(i_source, i_rs, i_reg_shift, i_imm_amt,
                                 i_shtype, i_carry, i_sat_dbl, i_tag));
    end
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [31:0] src, input logic [31:0] rs, input logic reg_sh,
                       input logic [4:0] imm, input logic [1:0] ty, input logic c,
                       input logic sat, input logic [7:0] tag);
    i_valid = 1'b1; i_source = src; i_rs = rs; i_reg_shift = reg_sh;
    i_imm_amt = imm; i_shtype = ty; i_carry = c; i_sat_dbl = sat; i_tag = tag;
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL reset_hs: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
    checks++;
    if ({o_source, o_amount, o_shift_type, o_carry, o_tag} !== '0) begin
      failures++; $display("FAIL reset_data: src=%h amt=%h ty=%0d c=%b tag=%h want all 0",
                           o_source, o_amount, o_shift_type, o_carry, o_tag);
    end
  endtask

  task automatic test_norm_directed();
    i_ready = 1'b1;
    drive(32'h8000_0000, 32'h0, 1'b0, 5'd0, 2'd2, 1'b0, 1'b0, 8'h11);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_shift_type !== 3'd2 || o_amount !== 8'd32 || o_source !== 32'h8000_0000) begin
      failures++; $display("FAIL asr0: valid=%b ty=%0d amt=%0d src=%h want 1/2/32/80000000",
                           o_valid, o_shift_type, o_amount, o_source);
    end
    drive(32'h1234_5678, 32'h0, 1'b0, 5'd0, 2'd3, 1'b1, 1'b0, 8'h22);
    tick();
    checks++;
    if (o_shift_type !== 3'd6 || o_amount !== 8'd0 || o_carry !== 1'b1 || o_tag !== 8'h22) begin
      failures++; $display("FAIL ror0_rrc: ty=%0d amt=%0d c=%b tag=%h want 6/0/1/22",
                           o_shift_type, o_amount, o_carry, o_tag);
    end
    drive(32'h1234_5678, 32'h0, 1'b0, 5'd8, 2'd3, 1'b0, 1'b0, 8'h33);
    tick();
    checks++;
    if (o_shift_type !== 3'd4 || o_amount !== 8'd8) begin
      failures++; $display("FAIL ror8: ty=%0d amt=%0d want 4/8", o_shift_type, o_amount);
    end
    drive(32'hcafe_f00d, 32'h0000_0121, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 8'h44);
    tick();
    checks++;
    if (o_shift_type !== 3'd1 || o_amount !== 8'h21) begin
      failures++; $display("FAIL reg_lsr: ty=%0d amt=%h want 1/21", o_shift_type, o_amount);
    end
    drive(32'h0000_0005, 32'h0000_0004, 1'b1, 5'd0, 2'd3, 1'b0, 1'b1, 8'h55);
    tick();
    checks++;
`ifdef ZAP_SHIFT_SAT_EN
    if (o_shift_type !== 3'd7 || o_amount !== 8'd1) begin
      failures++; $display("FAIL sat_dbl: ty=%0d amt=%0d want 7/1", o_shift_type, o_amount);
    end
`else
    if (o_shift_type !== 3'd3 || o_amount !== 8'd4) begin
      failures++; $display("FAIL sat_ignored: ty=%0d amt=%0d want 3/4", o_shift_type, o_amount);
    end
`endif
    i_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want_tag [3];
    logic       want_rdy [3];
    i_ready = 1'b0;
    want_rdy = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 1'b0, 5'(k + 1), 2'd0, 1'b0, 1'b0, 8'hA0 + 8'(k));
      tick();
      checks++;
      if (o_ready !== want_rdy[k] || o_valid !== 1'b1 || o_tag !== 8'hA0) begin
        failures++; $display("FAIL bp_fill%0d: ready=%b valid=%b tag=%h want %b/1/a0",
                             k, o_ready, o_valid, o_tag, want_rdy[k]);
      end
    end
    i_ready = 1'b1;
    want_tag = '{8'hA1, 8'hA2, 8'hA2};
    for (int k = 0; k < 3; k++) begin
      if (k == 2) i_valid = 1'b0;
      tick();
      checks++;
      if (k < 2 && (o_valid !== 1'b1 || o_ready !== 1'b1 || o_tag !== want_tag[k] ||
                    o_amount !== 8'(k + 2))) begin
        failures++; $display("FAIL bp_drain%0d: valid=%b ready=%b tag=%h amt=%0d want 1/1/%h/%0d",
                             k, o_valid, o_ready, o_tag, o_amount, want_tag[k], k + 2);
      end else if (k == 2 && o_valid !== 1'b0) begin
        failures++; $display("FAIL bp_end: valid=%b want 0", o_valid);
      end
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive($urandom, 32'h0, 1'b0, 5'd1, 2'd1, 1'b0, 1'b0, 8'hF0 + 8'(k));
      tick();
    end
    i_flush = 1'b1;
    drive(32'hdead_beef, 32'h0, 1'b0, 5'd2, 2'd0, 1'b1, 1'b0, 8'hEE);
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL flush_two: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
        failures++; $display("FAIL flush_ghost%0d: valid=%b tag=%h want 0", k, o_valid, o_tag);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            2'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0), 8'($urandom));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_flush = ($urandom_range(0, 40) == 0);
      tick();
      checks++;
      if (o_valid !== (q.size() != 0) || o_ready !== (q.size() < 2)) begin
        failures++; $display("FAIL rand_hs@%0d: valid=%b ready=%b want %b/%b", n, o_valid, o_ready,
                             q.size() != 0, q.size() < 2);
      end else if (q.size() != 0) begin
        exp_e = q[0];
        checks++;
        if ({o_source, o_amount, o_shift_type, o_carry, o_tag} !== exp_e) begin
          failures++; $display("FAIL rand_data@%0d: got %h_%h_%0d_%b_%h want %h_%h_%0d_%b_%h", n,
                               o_source, o_amount, o_shift_type, o_carry, o_tag,
                               exp_e.src, exp_e.amt, exp_e.ty, exp_e.c, exp_e.tag);
        end
      end
    end
    i_flush = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    drive(32'h1, 32'h0, 1'b0, 5'd1, 2'd0, 1'b0, 1'b0, 8'h77);
    tick();
    i_valid = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_tag !== 8'h00) begin
      failures++; $display("FAIL async_reset: valid=%b ready=%b tag=%h want 0/1/00", o_valid, o_ready, o_tag);
    end
    q.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    test_reset();
    i_reset_n = 1'b1;
    @(negedge i_clk);
    test_norm_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
